instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
Front end of the RV32 core. It owns the program counter and drives the fetch address to the byte-addressable instruction memory, which has a combinational read. It captures the returned instruction word, together with its PC, into the IF/ID pipeline register for the decoder. It handles stall, branch/jump redirect with flush, and termination when fetch runs off the end of memory or is redirected to a misaligned target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_BYTES, 100, instruction memory size in bytes. Last fetchable PC is IMEM_BYTES-4.
NOP_INSTR, 32'h0000_0013, bubble value (addi x0,x0,0) driven on if_id_instr when the slot is invalid.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
imem_addr  out  32  fetch address to instruction memory; equals current PC (combinational)
imem_rdata  in  32  instruction word returned for imem_addr, same cycle
stall  in  1  hazard stall from decode/execute; hold PC and IF/ID
redirect_valid  in  1  taken branch/jump; load redirect_target
redirect_target  in  32  new PC
if_id_valid  out  1  IF/ID slot holds a real instruction
if_id_pc  out  32  PC of captured instruction
if_id_pc_plus4  out  32  if_id_pc+4, used for jal/jalr link
if_id_instr  out  32  captured instruction, or NOP_INSTR when invalid
fetch_count  out  32  number of instructions captured since reset; wraps modulo 2^32
halted  out  1  fetch stopped because PC ran past memory (END state)
fault  out  1  misaligned redirect seen (FAULT state); sticky until reset

Behaviour:
- Reset values at the next clk edge while reset=1:
  - pc=RESET_PC, state=RUN
  - if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instr=NOP_INSTR
  - fetch_count=0, halted=0, fault=0
- Reset overrides all other inputs and takes effect mid-operation from any state.
- States:
  - RUN: fetching.
  - END: pc > IMEM_BYTES-4.
  - FAULT: misaligned redirect.
  - halted=(state==END); fault=(state==FAULT); both are registered.
- Per-edge priority in RUN: reset > redirect_valid > out-of-range > stall > normal fetch.
- Normal fetch (pc <= IMEM_BYTES-4, no stall, no redirect):
  - IF/ID captures {valid=1, pc, pc+4, imem_rdata}.
  - pc <= pc+4, fetch_count += 1.
  - Latency: instruction at PC X appears on if_id_* one edge after pc==X.
- Stall without redirect: pc, all IF/ID fields and fetch_count hold.
- Redirect with target[1:0]==0:
  - pc <= redirect_target.
  - IF/ID flushed: valid=0, instr=NOP_INSTR, pc fields hold.
  - fetch_count holds.
  - Applies even while stall=1, since redirect wins.
- Redirect with target[1:0]!=0:
  - pc holds, IF/ID flushed, state <= FAULT.
- Out of range in RUN (pc > IMEM_BYTES-4, no redirect):
  - No capture; IF/ID flushed.
  - state <= END, pc holds.
- END:
  - IF/ID stays invalid, pc holds.
  - An aligned redirect loads pc and returns to RUN; halted drops on that edge.
  - A misaligned redirect goes to FAULT.
- FAULT: absorbing. All inputs except reset are ignored, IF/ID stays invalid, pc holds.
- A redirect to an aligned but out-of-range target is accepted. The following edge then enters END.
- PC arithmetic is 32-bit unsigned, and pc+4 wraps. The range check uses unsigned compare.
- imem_addr is driven from the pc register only. There is no combinational path from redirect inputs to imem_addr.

Test Plan:
1. Memory {0:0x00002083, 4:0x00402103, 8:0x00802183}, reset 2 cycles then release -> first edge: if_id_valid=1, if_id_pc=0, if_id_instr=0x00002083, if_id_pc_plus4=4, imem_addr=4, fetch_count=1.
2. Run to pc=8, stall=1 for 3 cycles -> imem_addr stays 8, if_id_instr stays 0x00402103 with if_id_pc=4, fetch_count stays 2. Release stall -> next edge captures 0x00802183 at pc 8.
3. stall=1 and redirect_valid=1, target=0x18, with mem[0x18]=0x00202623 -> next edge: imem_addr=0x18, if_id_valid=0, if_id_instr=0x00000013. Following edge: if_id_pc=0x18, if_id_instr=0x00202623.
4. Redirect target=0x1A -> fault=1, if_id_valid=0, pc unchanged. Subsequent redirect to 0x0 and stall toggling -> no change. Reset -> fault=0, pc=0.
5. Free-run from 0 with no stalls -> 25 captures (pc 0..96), fetch_count=25. Edge at pc=100 -> halted=1, if_id_valid=0. Redirect to 0 -> halted=0, next capture at pc 0, fetch_count=26.
6. Assert reset for one cycle while pc=0x10 with if_id_valid=1 -> next edge: pc=0, if_id_valid=0, if_id_instr=0x00000013, fetch_count=0, halted=0, fault=0.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// RV32 fetch stage: owns the PC, drives a combinational-read imem, and fills the IF/ID register.
// Latency: one edge from pc==X to instruction X on if_id_*. Stall freezes PC/IF/ID; redirect overrides stall.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 100,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic [31:0] fetch_count,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_END   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        halted_q;
  logic        fault_q;
  logic        flush;
  logic        tgt_aligned;
  logic [31:0] pc_plus4;

  assign pc_plus4    = pc_q + 32'd4;
  assign tgt_aligned = (redirect_target[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;

    case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (tgt_aligned) begin
            pc_d = redirect_target;
          end else begin
            state_d = S_FAULT;
          end
        end else if (pc_q > LAST_PC) begin
          flush   = 1'b1;
          state_d = S_END;
        end else if (!stall) begin
          valid_d = 1'b1;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4;
          instr_d = imem_rdata;
          pc_d    = pc_plus4;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      S_END: begin
        // IF/ID is already a bubble here; a redirect only chooses where to go next.
        if (redirect_valid) begin
          flush = 1'b1;
          if (tgt_aligned) begin
            pc_d    = redirect_target;
            state_d = S_RUN;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: begin
      end
      default: begin
        flush   = 1'b1;
        state_d = S_FAULT;
      end
    endcase

    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      ipc_q    <= 32'd0;
      ipc4_q   <= 32'd0;
      instr_q  <= NOP_INSTR;
      cnt_q    <= 32'd0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      ipc_q    <= ipc_d;
      ipc4_q   <= ipc4_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == S_END);
      fault_q  <= (state_d == S_FAULT);
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_pc       = ipc_q;
  assign if_id_pc_plus4 = ipc4_q;
  assign if_id_instr    = instr_q;
  assign fetch_count    = cnt_q;
  assign halted         = halted_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed test-plan steps then random stall/redirect/reset traffic,
// every cycle compared against a rule-level model of the fetch stage.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic [31:0] fetch_count;
  logic        halted;
  logic        fault;

  logic [31:0] mem [0:31];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: observable architectural state only.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  bit          m_valid, m_halt, m_fault;

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < 32'd100) ? mem[imem_addr[6:2]]
                                            : (32'hBAD0_0000 ^ imem_addr);

  instr_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(100),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .fetch_count    (fetch_count),
    .halted         (halted),
    .fault          (fault)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd100) return mem[a[6:2]];
    return 32'hBAD0_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit st, input bit rv, input logic [31:0] tg);
    if (rst) begin
      m_pc = 32'd0; m_valid = 0; m_ipc = 32'd0; m_ipc4 = 32'd0;
      m_instr = NOP; m_cnt = 32'd0; m_halt = 0; m_fault = 0;
    end else if (m_fault) begin
      // absorbing until reset
    end else if (rv) begin
      m_valid = 0; m_instr = NOP;
      if (tg % 4 == 0) begin
        m_pc = tg; m_halt = 0;
      end else begin
        m_fault = 1; m_halt = 0;
      end
    end else if (m_halt) begin
      // parked past the end of memory
    end else if (m_pc > 32'd96) begin
      m_halt = 1; m_valid = 0; m_instr = NOP;
    end else if (!st) begin
      m_valid = 1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
      m_instr = mem_word(m_pc);
      m_pc = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".imem_addr"},   imem_addr,             m_pc);
    chk({ph, ".valid"},       {31'd0, if_id_valid},  {31'd0, m_valid});
    chk({ph, ".if_id_pc"},    if_id_pc,              m_ipc);
    chk({ph, ".pc_plus4"},    if_id_pc_plus4,        m_ipc4);
    chk({ph, ".instr"},       if_id_instr,           m_instr);
    chk({ph, ".fetch_count"}, fetch_count,           m_cnt);
    chk({ph, ".halted"},      {31'd0, halted},       {31'd0, m_halt});
    chk({ph, ".fault"},       {31'd0, fault},        {31'd0, m_fault});
  endtask

  task automatic cycle(input string ph, input bit rst, input bit st, input bit rv,
                       input logic [31:0] tg);
    reset = rst; stall = st; redirect_valid = rv; redirect_target = tg;
    @(posedge clk);
    model_edge(rst, st, rv, tg);
    #1;
    check_all(ph);
  endtask

  initial begin
    bit          rst, st, rv;
    logic [31:0] tg;
    int          k;

    for (int i = 0; i < 32; i++) mem[i] = $urandom();
    mem[0] = 32'h0000_2083;
    mem[1] = 32'h0040_2103;
    mem[2] = 32'h0080_2183;
    mem[6] = 32'h0020_2623;

    // 1: reset then first fetch
    cycle("rst", 1, 0, 0, 0);
    cycle("rst", 1, 0, 0, 0);
    chk("reset.instr", if_id_instr, NOP);
    chk("reset.count", fetch_count, 32'd0);
    cycle("tp1", 0, 0, 0, 0);
    chk("tp1.valid", {31'd0, if_id_valid}, 32'd1);
    chk("tp1.pc", if_id_pc, 32'd0);
    chk("tp1.instr", if_id_instr, 32'h0000_2083);
    chk("tp1.pc4", if_id_pc_plus4, 32'd4);
    chk("tp1.addr", imem_addr, 32'd4);
    chk("tp1.count", fetch_count, 32'd1);

    // 2: stall holds, release captures pc 8
    cycle("tp2", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("tp2s", 0, 1, 0, 0);
    chk("tp2.addr", imem_addr, 32'd8);
    chk("tp2.instr", if_id_instr, 32'h0040_2103);
    chk("tp2.pc", if_id_pc, 32'd4);
    chk("tp2.count", fetch_count, 32'd2);
    cycle("tp2r", 0, 0, 0, 0);
    chk("tp2r.instr", if_id_instr, 32'h0080_2183);
    chk("tp2r.pc", if_id_pc, 32'd8);

    // 3: redirect wins over stall
    cycle("tp3", 0, 1, 1, 32'h18);
    chk("tp3.addr", imem_addr, 32'h18);
    chk("tp3.valid", {31'd0, if_id_valid}, 32'd0);
    chk("tp3.instr", if_id_instr, NOP);
    cycle("tp3b", 0, 0, 0, 0);
    chk("tp3b.pc", if_id_pc, 32'h18);
    chk("tp3b.instr", if_id_instr, 32'h0020_2623);

    // 4: misaligned redirect is sticky
    cycle("tp4", 0, 0, 1, 32'h1A);
    chk("tp4.fault", {31'd0, fault}, 32'd1);
    chk("tp4.addr", imem_addr, 32'h1C);
    cycle("tp4x", 0, 0, 1, 32'h0);
    cycle("tp4x", 0, 1, 0, 32'h0);
    cycle("tp4x", 0, 0, 0, 32'h0);
    chk("tp4x.fault", {31'd0, fault}, 32'd1);
    cycle("tp4r", 1, 0, 0, 0);
    chk("tp4r.fault", {31'd0, fault}, 32'd0);
    chk("tp4r.addr", imem_addr, 32'd0);

    // 5: run off the end, then come back
    for (int i = 0; i < 25; i++) cycle("tp5", 0, 0, 0, 0);
    chk("tp5.count", fetch_count, 32'd25);
    chk("tp5.lastpc", if_id_pc, 32'd96);
    cycle("tp5e", 0, 0, 0, 0);
    chk("tp5e.halted", {31'd0, halted}, 32'd1);
    chk("tp5e.valid", {31'd0, if_id_valid}, 32'd0);
    cycle("tp5h", 0, 0, 0, 0);
    cycle("tp5d", 0, 0, 1, 32'h0);
    chk("tp5d.halted", {31'd0, halted}, 32'd0);
    cycle("tp5c", 0, 0, 0, 0);
    chk("tp5c.pc", if_id_pc, 32'd0);
    chk("tp5c.count", fetch_count, 32'd26);

    // 6: mid-run reset
    cycle("tp6", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("tp6", 0, 0, 0, 0);
    chk("tp6.pre", imem_addr, 32'h10);
    cycle("tp6r", 1, 0, 0, 0);
    chk("tp6r.addr", imem_addr, 32'd0);
    chk("tp6r.valid", {31'd0, if_id_valid}, 32'd0);
    chk("tp6r.instr", if_id_instr, NOP);
    chk("tp6r.count", fetch_count, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 29) == 0);
      st  = ($urandom_range(0, 9) < 3);
      rv  = 0;
      tg  = 32'd0;
      k   = $urandom_range(0, 59);
      if (k == 0) begin
        rv = 1; tg = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      end else if (k <= 5) begin
        rv = 1; tg = 32'($urandom_range(0, 24)) * 32'd4;
      end else if (k == 6) begin
        rv = 1; tg = (k % 2 == 0) ? 32'd100 : 32'hFFFF_FFFC;
        if ($urandom_range(0, 1) == 1) tg = $urandom() & 32'hFFFF_FFFC;
      end
      cycle("rand", rst, st, rv, tg);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
